systolic_array: RTL and testbench
=================================

# systolic_array

Parameterised N×N output-stationary systolic array that multiplies two unsigned N×N matrices, C = A·B. It is a self-starting compute block: the multiply begins when reset is released, and `done_o` flags that every element of `resultMatrix_o` is final. It sits between a matrix source that holds both operands in parallel and a consumer that reads the full result matrix.

## Interface
- `N`, default 4: matrix dimension and array size (N×N processing elements, PEs); N ≥ 2.
- `DATA_W`, default 4: operand element width, unsigned.
- `RES_W`, default 11: result element width, unsigned.
- `clk_i` input, 1 bit: the single clock. All state changes on the rising edge.
- `rst_i` input, 1 bit: reset, asynchronous and active-high.
- `MatA_i` input, `[DATA_W-1:0]`, unpacked `[N][N]`: matrix A, indexed `[row][col]`.
- `MatB_i` input, `[DATA_W-1:0]`, unpacked `[N][N]`: matrix B, indexed `[row][col]`.
- `resultMatrix_o` output, `[RES_W-1:0]`, unpacked `[N][N]`: matrix C, indexed `[row][col]`.
- `done_o` output, 1 bit: result valid, sticky.

## Operation
- Each PE(i,j) holds:
  - an accumulator `acc` (RES_W bits), which drives `resultMatrix_o[i][j]`;
  - registered copies of its a and b inputs, which it forwards right to PE(i,j+1) and down to PE(i+1,j).
- Feed step s runs from 0 to 3N−3, with s = (edge index − 1):
  - The left edge of row i receives A[i][s−i].
  - The top edge of column j receives B[s−j][j].
  - Any out-of-range index (outside 0..N−1) feeds 0.
- Because of this skew, A[i][k] and B[k][j] meet in PE(i,j) at step k+i+j. At that edge the PE performs `acc += a·b`.
- Arithmetic:
  - The product is computed at full 2·DATA_W width, unsigned.
  - The accumulation wraps modulo 2^RES_W and never saturates. The defaults cannot overflow: the maximum is 4·15·15 = 900.
- A step counter sequences the feed. When it reaches the final step:
  - `done_o` is set.
  - The counter, the feed and all accumulators freeze.
  - Results hold until the next reset.
- Reset (asynchronous) clears:
  - all accumulators, forwarded a/b registers, the counter and `done_o` to 0;
  - therefore `resultMatrix_o` reads all zeros.
- A reset asserted mid-operation aborts the multiply. On release the computation restarts from step 0.
- Operand stability: without the input latch, `MatA_i` and `MatB_i` must be held stable from reset release until `done_o` rises. Changes made after `done_o` rises have no effect.

## Timing
- Edge 1 is the first rising edge with `rst_i` low.
- Latency without the latch:
  - The last product lands in PE(N−1,N−1) at edge 3N−2.
  - `done_o` goes high on that same edge.
  - For N=4 this is edge 10.
- `resultMatrix_o` is final in the same cycle that `done_o` is first seen high.
- `done_o` stays high until `rst_i` is asserted. It is not a pulse.
- Intermediate cycles show partial sums. Consumers must qualify reads with `done_o`.

## Configuration
- Macro `SA_INPUT_LATCH_EN`, defined: both matrices are snapshotted into internal registers at edge 1.
  - Feeding starts from the snapshot.
  - All latencies shift by +1, so `done_o` rises at edge 3N−1 (edge 11 for N=4).
  - Inputs may change freely after edge 1.
- Macro `SA_INPUT_LATCH_EN`, undefined: the feeders read `MatA_i`/`MatB_i` directly and the stability rule in Operation applies.

## Test plan
- Directed matrices, with the register run to `done_o`:
  - A = {{1,1,10,8},{2,14,0,14},{1,4,11,15},{15,11,0,8}}
  - B = {{15,4,11,11},{11,5,9,14},{6,0,13,12},{0,4,10,14}}
  - Required C = {{86,41,230,257},{184,134,288,414},{125,84,340,409},{346,147,344,431}}.
- Identity: A = I, B = arbitrary → C = B exactly. Swapping (A arbitrary, B = I) → C = A.
- All operands 15 → every C element = 900. `done_o` rises at edge 10, or edge 11 with `SA_INPUT_LATCH_EN`.
- Reset state and stickiness:
  - During reset, `done_o` = 0 and all of C = 0.
  - After `done_o` rises, hold 5 extra cycles → C and `done_o` are unchanged.
- Mid-operation reset: assert `rst_i` at edge 5, release it, then run to completion → C is correct and `done_o` rises 3N−2 edges after the release.
- Parameter sweep with N=2 and A = {{1,2},{3,4}}, B = {{5,6},{7,8}} → C = {{19,22},{43,50}}, with `done_o` at edge 4.

Source files
------------

// File: rtl/systolic_array.sv
// Output-stationary N x N systolic multiplier, C = A * B, self-starting on reset release.
// Optional macro SA_INPUT_LATCH_EN snapshots both operand matrices at edge 1 and feeds from the copy.
//
// state  | meaning
// S_LOAD | capture operand snapshot (only used with SA_INPUT_LATCH_EN)
// S_RUN  | feeding skewed operands, one step per edge
// S_DONE | all products accumulated, everything frozen until reset
module systolic_array #(
    parameter int N      = 4,
    parameter int DATA_W = 4,
    parameter int RES_W  = 11
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] MatA_i         [N][N],
    input  logic [DATA_W-1:0] MatB_i         [N][N],
    output logic [RES_W-1:0]  resultMatrix_o [N][N],
    output logic              done_o
);

    localparam int LAST  = 3*N - 3;
    localparam int CNT_W = $clog2(LAST + 1);

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   step;
    logic               run;
    logic [DATA_W-1:0]  a_src [N][N];
    logic [DATA_W-1:0]  b_src [N][N];
    logic [DATA_W-1:0]  a_in  [N][N];
    logic [DATA_W-1:0]  b_in  [N][N];
    logic [DATA_W-1:0]  a_fwd [N][N];
    logic [DATA_W-1:0]  b_fwd [N][N];
    logic [2*DATA_W-1:0] prod [N][N];
    logic [RES_W-1:0]   acc   [N][N];

`ifdef SA_INPUT_LATCH_EN
    localparam state_t S_INIT = S_LOAD;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_src[i][j] <= '0;
                    b_src[i][j] <= '0;
                end
        end else if (state == S_LOAD) begin
            a_src <= MatA_i;
            b_src <= MatB_i;
        end
    end
`else
    localparam state_t S_INIT = S_RUN;

    assign a_src = MatA_i;
    assign b_src = MatB_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= S_INIT;
            step   <= '0;
            done_o <= 1'b0;
        end else begin
            case (state)
                S_LOAD: state <= S_RUN;
                S_RUN: begin
                    if (step == CNT_W'(LAST)) begin
                        state  <= S_DONE;
                        done_o <= 1'b1;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                S_DONE: state <= S_DONE;
                default: state <= S_INIT;
            endcase
        end
    end

    assign run = (state == S_RUN);

    // Edge feeders apply the diagonal skew; interior PEs take their neighbours' forwarded copies.
    always_comb begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_in[i][j] = '0;
                b_in[i][j] = '0;
            end
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++)
                if (int'(step) == i + k) a_in[i][0] = a_src[i][k];
        for (int j = 0; j < N; j++)
            for (int k = 0; k < N; k++)
                if (int'(step) == k + j) b_in[0][j] = b_src[k][j];
        for (int i = 0; i < N; i++)
            for (int j = 1; j < N; j++)
                a_in[i][j] = a_fwd[i][j-1];
        for (int i = 1; i < N; i++)
            for (int j = 0; j < N; j++)
                b_in[i][j] = b_fwd[i-1][j];
    end

    always_comb begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                prod[i][j] = {{DATA_W{1'b0}}, a_in[i][j]} * {{DATA_W{1'b0}}, b_in[i][j]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_fwd[i][j] <= '0;
                    b_fwd[i][j] <= '0;
                    acc[i][j]   <= '0;
                end
        end else if (run) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_fwd[i][j] <= a_in[i][j];
                    b_fwd[i][j] <= b_in[i][j];
                    acc[i][j]   <= acc[i][j] + RES_W'(prod[i][j]);
                end
        end
    end

    assign resultMatrix_o = acc;

endmodule

// File: tb/tb_systolic_array.sv
// Bench for systolic_array: directed and random matrices against a plain matrix-product model,
// plus latency, stickiness, mid-run reset and an N=2 instance.
module tb_systolic_array;
    localparam int N  = 4;
    localparam int DW = 4;
    localparam int RW = 11;
`ifdef SA_INPUT_LATCH_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rst2 = 1'b1;
    logic [DW-1:0] A  [N][N];
    logic [DW-1:0] B  [N][N];
    logic [RW-1:0] C  [N][N];
    logic          done;
    logic [DW-1:0] A2 [2][2];
    logic [DW-1:0] B2 [2][2];
    logic [RW-1:0] C2 [2][2];
    logic          done2;

    int ntests = 0;
    int nfail  = 0;
    int expC [N][N];

    int dA [N][N] = '{'{1,1,10,8}, '{2,14,0,14}, '{1,4,11,15}, '{15,11,0,8}};
    int dB [N][N] = '{'{15,4,11,11}, '{11,5,9,14}, '{6,0,13,12}, '{0,4,10,14}};
    int dC [N][N] = '{'{86,41,230,257}, '{184,134,288,414}, '{125,84,340,409}, '{346,147,344,431}};

    always #5 clk = ~clk;

    systolic_array #(.N(N), .DATA_W(DW), .RES_W(RW)) dut (
        .clk_i(clk), .rst_i(rst), .MatA_i(A), .MatB_i(B),
        .resultMatrix_o(C), .done_o(done)
    );

    systolic_array #(.N(2), .DATA_W(DW), .RES_W(RW)) dut2 (
        .clk_i(clk), .rst_i(rst2), .MatA_i(A2), .MatB_i(B2),
        .resultMatrix_o(C2), .done_o(done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                A[i][j] = 4'($urandom_range(0, 15));
                B[i][j] = 4'($urandom_range(0, 15));
            end
    endtask

    task automatic model();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int sum = 0;
                for (int k = 0; k < N; k++)
                    sum += int'(A[i][k]) * int'(B[k][j]);
                expC[i][j] = sum % (1 << RW);
            end
    endtask

    // Expects rst high on entry; checks reset state, releases, runs to done, checks result and hold.
    task automatic run(input string tag, input int exp_edge);
        int nz = 0;
        int edges = 0;
        @(negedge clk);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (C[i][j] !== '0) nz++;
        check({tag, "_rst_c"}, nz, 0);
        check({tag, "_rst_done"}, done, 0);
        rst = 1'b0;
        while (done !== 1'b1 && edges < 60) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, "_latency"}, edges, exp_edge);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("%s_c%0d%0d", tag, i, j), C[i][j], expC[i][j]);
        for (int n = 0; n < 5; n++) begin
            randomize_inputs();
            @(negedge clk);
        end
        nz = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (C[i][j] !== RW'(expC[i][j])) nz++;
        check({tag, "_hold_c"}, nz, 0);
        check({tag, "_hold_done"}, done, 1);
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                A2[i][j] = 4'(1 + 2*i + j);
                B2[i][j] = 4'(5 + 2*i + j);
            end
        randomize_inputs();
        repeat (2) @(negedge clk);

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                A[i][j] = 4'(dA[i][j]);
                B[i][j] = 4'(dB[i][j]);
                expC[i][j] = dC[i][j];
            end
        run("directed", 3*N - 2 + LAT);

        randomize_inputs();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                A[i][j] = (i == j) ? 4'd1 : 4'd0;
                expC[i][j] = int'(B[i][j]);
            end
        run("ident_a", 3*N - 2 + LAT);

        randomize_inputs();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                B[i][j] = (i == j) ? 4'd1 : 4'd0;
                expC[i][j] = int'(A[i][j]);
            end
        run("ident_b", 3*N - 2 + LAT);

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                A[i][j] = 4'd15;
                B[i][j] = 4'd15;
                expC[i][j] = 900;
            end
        run("all15", 3*N - 2 + LAT);

        for (int t = 0; t < 2; t++) begin
            randomize_inputs();
            model();
            run($sformatf("rand%0d", t), 3*N - 2 + LAT);
        end

        randomize_inputs();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("midrst_done_before", done, 0);
        rst = 1'b1;
        randomize_inputs();
        model();
        run("midrst", 3*N - 2 + LAT);

        begin
            int nz = 0;
            int edges = 0;
            int exp2 [2][2] = '{'{19,22}, '{43,50}};
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++)
                    if (C2[i][j] !== '0) nz++;
            check("n2_rst_c", nz, 0);
            check("n2_rst_done", done2, 0);
            rst2 = 1'b0;
            while (done2 !== 1'b1 && edges < 40) begin
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
            check("n2_latency", edges, 4 + LAT);
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++)
                    check($sformatf("n2_c%0d%0d", i, j), C2[i][j], exp2[i][j]);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
